uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 133 +++++++++++++
 tb/tb_uart_rx.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: start/data/optional parity/stop framing, 2-of-3 majority
// sampling around mid-bit, frame settings latched when the start edge is seen.
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] PRESCALE,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  busy
);

  localparam int BCW = $clog2(DATA_WIDTH + 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [PRESCALE_W-1:0]   r_edge_cnt;
  logic [PRESCALE_W-1:0]   r_prescale;
  logic                    r_par_en;
  logic                    r_par_typ;
  logic [BCW-1:0]          r_bit_cnt;
  logic [DATA_WIDTH-1:0]   r_shift;
  logic                    r_par_flag;
  logic [2:0]              r_samp;
  logic [DATA_WIDTH-1:0]   r_p_data;
  logic                    r_data_valid;
  logic                    r_par_err;
  logic                    r_stp_err;

  logic [PRESCALE_W-1:0]   w_half;
  logic                    w_last;
  logic                    w_bit;
  logic                    w_exp_par;

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

  assign w_half    = r_prescale >> 1;
  assign w_last    = (r_edge_cnt == r_prescale - PRESCALE_W'(1));
  assign w_bit     = maj3(r_samp);
  assign w_exp_par = (^r_shift) ^ r_par_typ;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (!RX_IN) w_next = START;
      START:   if (w_last) w_next = w_bit ? IDLE : DATA;
      DATA:    if (w_last && (r_bit_cnt == LAST_BIT)) w_next = r_par_en ? PARITY : STOP;
      PARITY:  if (w_last) w_next = STOP;
      STOP:    if (w_last) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_edge_cnt   <= '0;
      r_prescale   <= '0;
      r_par_en     <= 1'b0;
      r_par_typ    <= 1'b0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_par_flag   <= 1'b0;
      r_samp       <= '0;
      r_p_data     <= '0;
      r_data_valid <= 1'b0;
      r_par_err    <= 1'b0;
      r_stp_err    <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      r_par_err    <= 1'b0;
      r_stp_err    <= 1'b0;
      if (r_state == IDLE) begin
        r_edge_cnt <= RX_IN ? '0 : PRESCALE_W'(1);
        // Frame settings are frozen here so mid-frame input changes are ignored
        if (!RX_IN) begin
          r_prescale <= PRESCALE;
          r_par_en   <= PAR_EN;
          r_par_typ  <= PAR_TYP;
          r_par_flag <= 1'b0;
          r_bit_cnt  <= '0;
        end
      end else begin
        r_edge_cnt <= w_last ? '0 : r_edge_cnt + PRESCALE_W'(1);
        if (r_edge_cnt == w_half - PRESCALE_W'(1)) r_samp[0] <= RX_IN;
        if (r_edge_cnt == w_half)                  r_samp[1] <= RX_IN;
        if (r_edge_cnt == w_half + PRESCALE_W'(1)) r_samp[2] <= RX_IN;
        if (w_last) begin
          case (r_state)
            START:  r_bit_cnt <= '0;
            DATA: begin
              r_shift   <= {w_bit, r_shift[DATA_WIDTH-1:1]};
              r_bit_cnt <= r_bit_cnt + BCW'(1);
            end
            PARITY: if (w_bit != w_exp_par) r_par_flag <= 1'b1;
            STOP: begin
              if (w_bit && !r_par_flag) begin
                r_p_data     <= r_shift;
                r_data_valid <= 1'b1;
              end
              r_stp_err <= ~w_bit;
              r_par_err <= r_par_flag;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign P_DATA     = r_p_data;
  assign data_valid = r_data_valid;
  assign par_err    = r_par_err;
  assign stp_err    = r_stp_err;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: good frames, back-to-back, parity/stop errors,
// start glitch and mid-frame reset, with hand-computed expectations.
module tb_uart_rx;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic [5:0] PRESCALE;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int dv_cnt = 0, pe_cnt = 0, se_cnt = 0, long_cnt = 0;
  logic prev_dv = 1'b0, prev_pe = 1'b0, prev_se = 1'b0;
  int b_dv, b_pe, b_se;

  uart_rx #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PRESCALE(PRESCALE),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .P_DATA(P_DATA),
    .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err), .busy(busy)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Pulse counters and a detector for any pulse lasting more than one cycle
  always @(negedge CLK) begin
    if (data_valid) dv_cnt++;
    if (par_err)    pe_cnt++;
    if (stp_err)    se_cnt++;
    if ((data_valid && prev_dv) || (par_err && prev_pe) || (stp_err && prev_se)) long_cnt++;
    prev_dv = data_valid;
    prev_pe = par_err;
    prev_se = stp_err;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b, input int p);
    RX_IN = b;
    repeat (p) @(negedge CLK);
  endtask

  // Returns on the falling edge right after the stop bit's last rising edge
  task automatic send_frame(input int p, input logic pe, input logic pt,
                            input logic [7:0] d, input logic pbit, input logic sbit);
    PRESCALE = 6'(p);
    PAR_EN   = pe;
    PAR_TYP  = pt;
    send_bit(1'b0, p);
    PRESCALE = (p == 8) ? 6'd16 : 6'd8;
    PAR_EN   = ~pe;
    PAR_TYP  = ~pt;
    for (int i = 0; i < 8; i++) send_bit(d[i], p);
    if (pe) send_bit(pbit, p);
    send_bit(sbit, p);
  endtask

  task automatic snap();
    b_dv = dv_cnt;
    b_pe = pe_cnt;
    b_se = se_cnt;
  endtask

  initial begin
    RST = 1'b1; RX_IN = 1'b1; PRESCALE = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_pdata", 32'(P_DATA), 32'h0);
    check("rst_dv",    32'(data_valid), 32'h0);
    check("rst_pe",    32'(par_err), 32'h0);
    check("rst_se",    32'(stp_err), 32'h0);
    check("rst_busy",  32'(busy), 32'h0);
    RST = 1'b0;
    repeat (3) @(negedge CLK);

    // P=8, even parity, 0xA5 (four ones -> parity 0)
    snap();
    send_frame(8, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1);
    check("t1_dv_at_87", 32'(data_valid), 32'h1);
    check("t1_pdata",    32'(P_DATA), 32'hA5);
    check("t1_pe",       32'(par_err), 32'h0);
    check("t1_se",       32'(stp_err), 32'h0);
    @(negedge CLK);
    check("t1_dv_drop",  32'(data_valid), 32'h0);
    repeat (2) @(negedge CLK);
    check("t1_dv_count", 32'(dv_cnt - b_dv), 32'h1);

    // P=16, no parity, 0x3C then back-to-back 0xC3
    snap();
    send_frame(16, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1);
    check("t2a_dv_at_159", 32'(data_valid), 32'h1);
    check("t2a_pdata",     32'(P_DATA), 32'h3C);
    send_frame(16, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1);
    check("t2b_dv",        32'(data_valid), 32'h1);
    check("t2b_pdata",     32'(P_DATA), 32'hC3);
    repeat (2) @(negedge CLK);
    check("t2_dv_count",   32'(dv_cnt - b_dv), 32'h2);
    check("t2_err_count",  32'(pe_cnt - b_pe + se_cnt - b_se), 32'h0);

    // P=8, odd parity, 0xA5 sent with parity 0 (odd expects 1)
    snap();
    send_frame(8, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b1);
    check("t3_pe_at_87", 32'(par_err), 32'h1);
    check("t3_dv",       32'(data_valid), 32'h0);
    check("t3_se",       32'(stp_err), 32'h0);
    check("t3_pdata",    32'(P_DATA), 32'hC3);
    repeat (2) @(negedge CLK);
    check("t3_pe_count", 32'(pe_cnt - b_pe), 32'h1);
    check("t3_dv_count", 32'(dv_cnt - b_dv), 32'h0);

    // P=8 start glitch: low for two cycles, then high
    snap();
    PRESCALE = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    RX_IN = 1'b0;
    repeat (2) @(negedge CLK);
    RX_IN = 1'b1;
    repeat (5) @(negedge CLK);
    check("t4_busy_e6", 32'(busy), 32'h1);
    @(negedge CLK);
    check("t4_busy_e7", 32'(busy), 32'h0);
    repeat (20) @(negedge CLK);
    check("t4_pulses", 32'(dv_cnt - b_dv + pe_cnt - b_pe + se_cnt - b_se), 32'h0);

    // P=32, no parity, stop bit 0
    snap();
    send_frame(32, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0);
    check("t5_se_at_319", 32'(stp_err), 32'h1);
    check("t5_pe",        32'(par_err), 32'h0);
    check("t5_dv",        32'(data_valid), 32'h0);
    check("t5_pdata",     32'(P_DATA), 32'hC3);
    RX_IN = 1'b1;
    repeat (2) @(negedge CLK);
    check("t5_se_count",  32'(se_cnt - b_se), 32'h1);
    check("t5_dv_count",  32'(dv_cnt - b_dv), 32'h0);

    // P=32 frame aborted by reset on edge 100
    snap();
    fork
      send_frame(32, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1);
      begin
        repeat (100) @(negedge CLK);
        check("t6_busy_pre", 32'(busy), 32'h1);
        RST = 1'b1;
        @(negedge CLK);
        check("t6_pdata", 32'(P_DATA), 32'h0);
        check("t6_busy",  32'(busy), 32'h0);
        check("t6_flags", 32'({data_valid, par_err, stp_err}), 32'h0);
        RST = 1'b0;
      end
    join
    repeat (40) @(negedge CLK);
    check("t6_pulses",   32'(dv_cnt - b_dv + pe_cnt - b_pe + se_cnt - b_se), 32'h0);
    check("t6_idle",     32'(busy), 32'h0);
    check("t6_pdata_end", 32'(P_DATA), 32'h0);

    check("one_cycle_pulses", 32'(long_cnt), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
